// File: rtl/zx_ports_pkg.sv
// Shared types, constants and port-decode helpers for the Spectrum I/O port block.
package zx_ports_pkg;

  typedef enum logic [1:0] {
    MACHINE_S48  = 2'd0,
    MACHINE_S128 = 2'd1,
    MACHINE_PENT = 2'd2,
    MACHINE_S3   = 2'd3
  } machine_t;

  typedef struct packed {
    logic [2:0] ram;
    logic       scr;
    logic       rom;
    logic       lock;
  } port7ffd_t;

  localparam int PORT_FE_BITS   = 5;
  localparam int PORT_1FFD_BITS = 4;
  localparam int LOCK_BIT       = 5;

  function automatic logic match_fe(input logic [15:0] a, input logic full);
    return full ? (a[7:0] == 8'hFE) : !a[0];
  endfunction

  // Each machine decodes #7FFD with a different partial address mask.
  function automatic logic match_7ffd(input machine_t m, input logic [15:0] a);
    logic hit;
    hit = 1'b0;
    case (m)
      MACHINE_S128, MACHINE_PENT: hit = !a[15] && !a[1];
      MACHINE_S3:                 hit = (a[15:14] == 2'b01) && !a[1];
      default:                    hit = 1'b0;
    endcase
    return hit;
  endfunction

  function automatic logic match_1ffd(input machine_t m, input logic [15:0] a);
    return (m == MACHINE_S3) && (a[15:12] == 4'b0001) && !a[1];
  endfunction

endpackage

// File: rtl/zx_ports_if.sv
// Registered CPU bus as seen by the I/O port block.
interface cpu_bus;
  logic [15:0] a_reg;
  logic [7:0]  d_reg;
  logic        ioreq;
  logic        wr;

  modport master (output a_reg, d_reg, ioreq, wr);
  modport slave  (input  a_reg, d_reg, ioreq, wr);
endinterface

// File: rtl/zx_ports_io_wr_strobe.sv
// Single-cycle I/O write strobe and machine-change detector.
module io_wr_strobe
  import zx_ports_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     iowr_i,
  input  machine_t machine_i,
  output logic     wr_stb_o,
  output logic     machine_changed_o,
  output machine_t machine_q_o
);

  logic     iowr_q;
  machine_t machine_q;

  // The machine copy tracks the input even in reset so no change is seen on release.
  always_ff @(posedge clk) begin
    machine_q <= machine_i;
    if (rst) begin
      iowr_q <= 1'b0;
    end else begin
      iowr_q <= iowr_i;
    end
  end

  assign wr_stb_o          = iowr_i && !iowr_q;
  assign machine_changed_o = (machine_i != machine_q);
  assign machine_q_o       = machine_q;

endmodule

// File: rtl/zx_ports.sv
// Z80 port register block: #FE border/beeper/tape, #7FFD paging/lock, #1FFD +3 config.
module zx_ports
  import zx_ports_pkg::*;
#(
  parameter bit FE_FULL_DECODE = 1'b0
) (
  input  logic       clk28,
  input  logic       rst,
  input  machine_t   machine,
  cpu_bus.slave      bus,
  output logic [2:0] border,
  output logic       beeper,
  output logic       tape_out,
  output logic [2:0] ram_page,
  output logic       screen_page,
  output logic [1:0] rom_page,
  output logic       lock_7ffd,
  output logic       special_mode,
  output logic [1:0] special_cfg,
  output logic       disk_motor,
  output logic       port_wr_hit
);

  logic     iowr;
  logic     wr_stb;
  logic     machine_changed;
  machine_t machine_q;

  logic [PORT_FE_BITS-1:0]   fe_q, fe_d;
  port7ffd_t                 p7ffd_q, p7ffd_d;
  logic [PORT_1FFD_BITS-1:0] p1ffd_q, p1ffd_d;
  logic                      hit_q, hit_d;
  logic                      hit_fe, hit_7ffd, hit_1ffd;
  logic [1:0]                rom_page_sel;
  logic                      unused_d_bits;

  assign iowr          = bus.ioreq && bus.wr;
  assign unused_d_bits = ^bus.d_reg[7:6];

  io_wr_strobe u_wr_strobe (
    .clk               (clk28),
    .rst               (rst),
    .iowr_i            (iowr),
    .machine_i         (machine),
    .wr_stb_o          (wr_stb),
    .machine_changed_o (machine_changed),
    .machine_q_o       (machine_q)
  );

  always_comb begin
    hit_fe   = wr_stb && match_fe(bus.a_reg, FE_FULL_DECODE);
    hit_7ffd = wr_stb && match_7ffd(machine_q, bus.a_reg);
    hit_1ffd = wr_stb && match_1ffd(machine_q, bus.a_reg);

    fe_d    = fe_q;
    p7ffd_d = p7ffd_q;
    p1ffd_d = p1ffd_q;
    hit_d   = hit_fe || hit_7ffd || hit_1ffd;

    if (hit_fe) begin
      fe_d = bus.d_reg[PORT_FE_BITS-1:0];
    end
    // Lock is checked against the current value, so the locking write lands in full.
    if (hit_7ffd && !p7ffd_q.lock) begin
      p7ffd_d.ram  = bus.d_reg[2:0];
      p7ffd_d.scr  = bus.d_reg[3];
      p7ffd_d.rom  = bus.d_reg[4];
      p7ffd_d.lock = bus.d_reg[LOCK_BIT];
    end
    if (hit_1ffd && !p7ffd_q.lock) begin
      p1ffd_d = bus.d_reg[PORT_1FFD_BITS-1:0];
    end
    if (machine_changed) begin
      p7ffd_d = '0;
      p1ffd_d = '0;
    end
  end

  always_ff @(posedge clk28) begin
    if (rst) begin
      fe_q    <= '0;
      p7ffd_q <= '0;
      p1ffd_q <= '0;
      hit_q   <= 1'b0;
    end else begin
      fe_q    <= fe_d;
      p7ffd_q <= p7ffd_d;
      p1ffd_q <= p1ffd_d;
      hit_q   <= hit_d;
    end
  end

  always_comb begin
    rom_page_sel = 2'b00;
    case (machine_q)
      MACHINE_S128, MACHINE_PENT: rom_page_sel = {1'b0, p7ffd_q.rom};
      MACHINE_S3:                 rom_page_sel = {p1ffd_q[2], p7ffd_q.rom};
      default:                    rom_page_sel = 2'b00;
    endcase
  end

  assign border       = fe_q[2:0];
  assign tape_out     = fe_q[3];
  assign beeper       = fe_q[4];
  assign ram_page     = p7ffd_q.ram;
  assign screen_page  = p7ffd_q.scr;
  assign lock_7ffd    = p7ffd_q.lock;
  assign rom_page     = rom_page_sel;
  assign special_mode = p1ffd_q[0];
  assign special_cfg  = p1ffd_q[2:1];
  assign disk_motor   = p1ffd_q[3];
  assign port_wr_hit  = hit_q;

endmodule

// File: tb/tb_zx_ports.sv
// Scoreboard bench for zx_ports: a reference port model pushes expected outputs per write.
`timescale 1ns/1ps
module tb_zx_ports;
  import zx_ports_pkg::*;

  typedef struct packed {
    logic [2:0] border;
    logic       beeper;
    logic       tape;
    logic [2:0] ram;
    logic       scr;
    logic [1:0] rom;
    logic       lock;
    logic       smode;
    logic [1:0] scfg;
    logic       motor;
    logic       hit;
  } out_t;

  logic clk28 = 1'b0;
  always #5 clk28 = ~clk28;

  logic       rst;
  machine_t   machine;
  logic [2:0] border;
  logic       beeper, tape_out;
  logic [2:0] ram_page;
  logic       screen_page;
  logic [1:0] rom_page;
  logic       lock_7ffd, special_mode;
  logic [1:0] special_cfg;
  logic       disk_motor, port_wr_hit;

  cpu_bus bus_if ();

  zx_ports #(.FE_FULL_DECODE(1'b0)) dut (
    .clk28        (clk28),
    .rst          (rst),
    .machine      (machine),
    .bus          (bus_if),
    .border       (border),
    .beeper       (beeper),
    .tape_out     (tape_out),
    .ram_page     (ram_page),
    .screen_page  (screen_page),
    .rom_page     (rom_page),
    .lock_7ffd    (lock_7ffd),
    .special_mode (special_mode),
    .special_cfg  (special_cfg),
    .disk_motor   (disk_motor),
    .port_wr_hit  (port_wr_hit)
  );

  int   n_chk  = 0;
  int   n_fail = 0;
  out_t sb[$];
  out_t obs, exp_v;
  int   extra;

  // Reference model state
  logic [2:0] m_border;
  logic       m_beep, m_tape;
  logic [2:0] m_ram;
  logic       m_scr, m_rom, m_lock;
  logic [3:0] m_1ffd;
  machine_t   m_mach;

  task automatic tick();
    @(posedge clk28);
    #1;
  endtask

  function automatic out_t snap();
    return {border, beeper, tape_out, ram_page, screen_page, rom_page,
            lock_7ffd, special_mode, special_cfg, disk_motor, port_wr_hit};
  endfunction

  function automatic out_t model_out(input logic hit);
    logic [1:0] rp;
    case (m_mach)
      MACHINE_S48: rp = 2'b00;
      MACHINE_S3:  rp = {m_1ffd[2], m_rom};
      default:     rp = {1'b0, m_rom};
    endcase
    return {m_border, m_beep, m_tape, m_ram, m_scr, rp, m_lock,
            m_1ffd[0], m_1ffd[2:1], m_1ffd[3], hit};
  endfunction

  task automatic model_clear_paging();
    m_ram = 3'd0; m_scr = 1'b0; m_rom = 1'b0; m_lock = 1'b0; m_1ffd = 4'd0;
  endtask

  task automatic model_reset();
    model_clear_paging();
    m_border = 3'd0; m_beep = 1'b0; m_tape = 1'b0;
  endtask

  // Drives an I/O write and pushes the state expected after the next edge.
  task automatic start_write(input logic [15:0] a, input logic [7:0] d);
    logic fe, p7, p1;
    bus_if.a_reg = a;
    bus_if.d_reg = d;
    bus_if.ioreq = 1'b1;
    bus_if.wr    = 1'b1;
    fe = (a[0] == 1'b0);
    p7 = 1'b0;
    if (m_mach == MACHINE_S128 || m_mach == MACHINE_PENT) p7 = !a[15] && !a[1];
    else if (m_mach == MACHINE_S3) p7 = (a[15:14] == 2'b01) && !a[1];
    p1 = (m_mach == MACHINE_S3) && (a[15:12] == 4'b0001) && !a[1];
    if (fe) begin
      m_border = d[2:0]; m_tape = d[3]; m_beep = d[4];
    end
    if (!m_lock) begin
      if (p1) m_1ffd = d[3:0];
      if (p7) begin
        m_ram = d[2:0]; m_scr = d[3]; m_rom = d[4]; m_lock = d[5];
      end
    end
    sb.push_back(model_out(fe || p7 || p1));
  endtask

  // Holds the write for the rest of its cycles, releases it, and counts stray hit pulses.
  task automatic finish_write(input int hold, output int hits);
    hits = 0;
    for (int i = 1; i < hold; i++) begin
      tick();
      hits += int'(port_wr_hit);
    end
    bus_if.ioreq = 1'b0;
    bus_if.wr    = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      hits += int'(port_wr_hit);
    end
  endtask

  task automatic change_machine(input machine_t m);
    machine = m;
    m_mach  = m;
    model_clear_paging();
    sb.push_back(model_out(1'b0));
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    machine = MACHINE_S48;
    bus_if.a_reg = 16'h0000; bus_if.d_reg = 8'h00;
    bus_if.ioreq = 1'b0; bus_if.wr = 1'b0;
    repeat (3) tick();
    obs = snap();
    n_chk++;
    if (obs !== '0) begin
      n_fail++;
      $display("FAIL reset_hold: got %h want %h", obs, out_t'('0));
    end
    rst = 1'b0;
    m_mach = MACHINE_S48;
    model_reset();
    sb.push_back(model_out(1'b0));
    tick();
    exp_v = sb.pop_front(); obs = snap();
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL reset_release: got %h want %h", obs, exp_v);
    end
    $display("reset: outputs %h", obs);
  endtask

  task automatic test_fe_write();
    start_write(16'h00FE, 8'h17);
    tick();
    exp_v = sb.pop_front(); obs = snap();
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL fe_sb: got %h want %h", obs, exp_v);
    end
    n_chk++;
    if (border !== 3'd7 || beeper !== 1'b1 || tape_out !== 1'b0) begin
      n_fail++;
      $display("FAIL fe_vals: got border=%0d beeper=%b tape=%b want 7 1 0", border, beeper, tape_out);
    end
    finish_write(10, extra);
    n_chk++;
    if (extra !== 0) begin
      n_fail++;
      $display("FAIL fe_one_strobe: got %0d hits want 1", 1 + extra);
    end
    $display("write #FE=17 held 10: border=%0d beeper=%b tape=%b", border, beeper, tape_out);
  endtask

  task automatic test_7ffd_lock();
    logic [7:0] data [3] = '{8'h1D, 8'h20, 8'h07};
    change_machine(MACHINE_S128);
    exp_v = sb.pop_front(); obs = snap();
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL to_s128: got %h want %h", obs, exp_v);
    end
    for (int i = 0; i < 3; i++) begin
      start_write(16'h7FFD, data[i]);
      tick();
      exp_v = sb.pop_front(); obs = snap();
      n_chk++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL s128_7ffd_%0d: got %h want %h", i, obs, exp_v);
      end
      n_chk++;
      if (port_wr_hit !== 1'b1) begin
        n_fail++;
        $display("FAIL s128_hit_%0d: got %b want 1", i, port_wr_hit);
      end
      finish_write(2, extra);
      $display("write #7FFD=%h: ram=%0d scr=%b rom=%b lock=%b", data[i], ram_page, screen_page, rom_page, lock_7ffd);
    end
    n_chk++;
    if (ram_page !== 3'd0 || lock_7ffd !== 1'b1) begin
      n_fail++;
      $display("FAIL s128_locked: got ram=%0d lock=%b want 0 1", ram_page, lock_7ffd);
    end
  endtask

  task automatic test_plus3();
    change_machine(MACHINE_S3);
    exp_v = sb.pop_front(); obs = snap();
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL to_s3: got %h want %h", obs, exp_v);
    end
    start_write(16'h1FFD, 8'h0D); tick();
    exp_v = sb.pop_front(); obs = snap();
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL s3_1ffd: got %h want %h", obs, exp_v);
    end
    finish_write(1, extra);
    start_write(16'h7FFD, 8'h10); tick();
    exp_v = sb.pop_front(); obs = snap();
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL s3_7ffd: got %h want %h", obs, exp_v);
    end
    n_chk++;
    if (special_mode !== 1'b1 || special_cfg !== 2'b10 || disk_motor !== 1'b1 || rom_page !== 2'b11) begin
      n_fail++;
      $display("FAIL s3_vals: got mode=%b cfg=%b motor=%b rom=%b want 1 10 1 11",
               special_mode, special_cfg, disk_motor, rom_page);
    end
    finish_write(1, extra);
    $display("+3 #1FFD=0D #7FFD=10: mode=%b cfg=%b motor=%b rom=%b", special_mode, special_cfg, disk_motor, rom_page);
    change_machine(MACHINE_S128);
    exp_v = sb.pop_front(); obs = snap();
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL s3_to_s128: got %h want %h", obs, exp_v);
    end
    start_write(16'h1FFD, 8'h0D); tick();
    exp_v = sb.pop_front(); obs = snap();
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL s128_1ffd: got %h want %h", obs, exp_v);
    end
    n_chk++;
    if (special_mode !== 1'b0 || special_cfg !== 2'b00 || disk_motor !== 1'b0) begin
      n_fail++;
      $display("FAIL s128_1ffd_ignored: got mode=%b cfg=%b motor=%b want 0 00 0", special_mode, special_cfg, disk_motor);
    end
    finish_write(1, extra);
    $display("S128 #1FFD=0D: mode=%b cfg=%b motor=%b ram=%0d", special_mode, special_cfg, disk_motor, ram_page);
  endtask

  task automatic test_multi_port();
    start_write(16'h7FFC, 8'h03); tick();
    exp_v = sb.pop_front(); obs = snap();
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL multi_sb: got %h want %h", obs, exp_v);
    end
    n_chk++;
    if (border !== 3'd3 || ram_page !== 3'd3) begin
      n_fail++;
      $display("FAIL multi_vals: got border=%0d ram=%0d want 3 3", border, ram_page);
    end
    finish_write(1, extra);
    $display("S128 #7FFC=03: border=%0d ram=%0d", border, ram_page);
    change_machine(MACHINE_S48);
    exp_v = sb.pop_front(); obs = snap();
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL to_s48: got %h want %h", obs, exp_v);
    end
    n_chk++;
    if (ram_page !== 3'd0 || lock_7ffd !== 1'b0 || border !== 3'd3) begin
      n_fail++;
      $display("FAIL s48_keep: got ram=%0d lock=%b border=%0d want 0 0 3", ram_page, lock_7ffd, border);
    end
    $display("to S48: ram=%0d lock=%b border=%0d", ram_page, lock_7ffd, border);
  endtask

  task automatic test_change_collision();
    change_machine(MACHINE_S128);
    exp_v = sb.pop_front(); obs = snap();
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL to_s128_b: got %h want %h", obs, exp_v);
    end
    // Machine change and write strobe on the same edge.
    machine = MACHINE_PENT;
    bus_if.a_reg = 16'h7FFD; bus_if.d_reg = 8'h06;
    bus_if.ioreq = 1'b1; bus_if.wr = 1'b1;
    m_mach = MACHINE_PENT;
    model_clear_paging();
    tick();
    n_chk++;
    if (ram_page !== 3'd0 || lock_7ffd !== 1'b0) begin
      n_fail++;
      $display("FAIL collide_clear: got ram=%0d lock=%b want 0 0", ram_page, lock_7ffd);
    end
    finish_write(3, extra);
    n_chk++;
    if (ram_page !== 3'd0 || extra !== 0) begin
      n_fail++;
      $display("FAIL collide_after: got ram=%0d hits=%0d want 0 0", ram_page, extra);
    end
    $display("S128->PENT with #7FFD=06: ram=%0d", ram_page);
  endtask

  task automatic test_reset_mid_write();
    start_write(16'h7FFD, 8'h02); tick();
    exp_v = sb.pop_front(); obs = snap();
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL pre_rst_write: got %h want %h", obs, exp_v);
    end
    rst = 1'b1;
    tick(); tick();
    obs = snap();
    n_chk++;
    if (obs !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_write: got %h want %h", obs, out_t'('0));
    end
    rst = 1'b0;
    model_reset();
    start_write(16'h7FFD, 8'h02);
    tick();
    exp_v = sb.pop_front(); obs = snap();
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL post_rst_strobe: got %h want %h", obs, exp_v);
    end
    finish_write(4, extra);
    n_chk++;
    if (extra !== 0 || ram_page !== 3'd2) begin
      n_fail++;
      $display("FAIL post_rst_once: got hits=%0d ram=%0d want 0 2", extra, ram_page);
    end
    $display("rst during held write then release: ram=%0d extra_hits=%0d", ram_page, extra);
  endtask

  initial begin
    test_reset();
    test_fe_write();
    test_7ffd_lock();
    test_plus3();
    test_multi_port();
    test_change_collision();
    test_reset_mid_write();
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
